// File: rtl/mc_controller.sv
// Multicycle RISC-V control FSM: Moore decode of op into datapath selects and write strobes.
// Latency: 3-5 cycles per instruction with mem_ready high; each mem_ready=0 cycle in FETCH/MEMREAD/MEMWRITE adds one.
// Backpressure: memory states hold (strobes still asserted) until mem_ready, unless MEM_HANDSHAKE=0.
module mc_controller #(
    parameter int MEM_HANDSHAKE = 1,
    parameter int ILLEGAL_HALT  = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       branch,
    output logic       adr_src,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [2:0] imm_src,
    output logic       illegal,
    output logic [3:0] state
);

    localparam logic [3:0] st_fetch    = 4'd0;
    localparam logic [3:0] st_decode   = 4'd1;
    localparam logic [3:0] st_memadr   = 4'd2;
    localparam logic [3:0] st_memread  = 4'd3;
    localparam logic [3:0] st_memwb    = 4'd4;
    localparam logic [3:0] st_memwrite = 4'd5;
    localparam logic [3:0] st_execr    = 4'd6;
    localparam logic [3:0] st_execi    = 4'd7;
    localparam logic [3:0] st_aluwb    = 4'd8;
    localparam logic [3:0] st_jal      = 4'd9;
    localparam logic [3:0] st_beq      = 4'd10;
    localparam logic [3:0] st_lui      = 4'd11;
    localparam logic [3:0] st_jalr     = 4'd12;
    localparam logic [3:0] st_jalrwb   = 4'd13;
    localparam logic [3:0] st_illegal  = 4'd15;

    localparam logic [6:0] op_r    = 7'b0110011;
    localparam logic [6:0] op_i    = 7'b0010011;
    localparam logic [6:0] op_lw   = 7'b0000011;
    localparam logic [6:0] op_sw   = 7'b0100011;
    localparam logic [6:0] op_b    = 7'b1100011;
    localparam logic [6:0] op_jal  = 7'b1101111;
    localparam logic [6:0] op_jalr = 7'b1100111;
    localparam logic [6:0] op_lui  = 7'b0110111;

    logic [3:0]  cur_st;
    logic [3:0]  nxt_st;
    logic        rdy;
    logic [15:0] ctl;
    logic [2:0]  imm;

    assign rdy = (MEM_HANDSHAKE == 0) ? 1'b1 : mem_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cur_st <= st_fetch;
        else      cur_st <= nxt_st;
    end

    // ctl packing: pc_write, branch, adr_src, mem_read, mem_write, ir_write,
    // reg_write, result_src[1:0], alu_src_a[1:0], alu_src_b[1:0], alu_op[1:0], illegal
    always_comb begin
        nxt_st = cur_st;
        ctl    = '0;
        case (cur_st)
            st_fetch: begin
                ctl = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0};
                if (rdy) begin
                    ctl[15] = 1'b1;
                    ctl[10] = 1'b1;
                    nxt_st  = st_decode;
                end
            end
            st_decode: begin
                ctl = {7'b0, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0};
                case (op)
                    op_lw, op_sw: nxt_st = st_memadr;
                    op_r:         nxt_st = st_execr;
                    op_i:         nxt_st = st_execi;
                    op_b:         nxt_st = st_beq;
                    op_jal:       nxt_st = st_jal;
                    op_jalr:      nxt_st = st_jalr;
                    op_lui:       nxt_st = st_lui;
                    default:      nxt_st = st_illegal;
                endcase
            end
            st_memadr: begin
                ctl    = {7'b0, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0};
                nxt_st = (op == op_sw) ? st_memwrite : st_memread;
            end
            st_memread: begin
                ctl = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
                if (rdy) nxt_st = st_memwb;
            end
            st_memwb: begin
                ctl    = {6'b0, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0};
                nxt_st = st_fetch;
            end
            st_memwrite: begin
                ctl = {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
                if (rdy) nxt_st = st_fetch;
            end
            st_execr: begin
                ctl    = {7'b0, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0};
                nxt_st = st_aluwb;
            end
            st_execi: begin
                ctl    = {7'b0, 2'b00, 2'b10, 2'b01, 2'b10, 1'b0};
                nxt_st = st_aluwb;
            end
            st_aluwb: begin
                ctl    = {6'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
                nxt_st = st_fetch;
            end
            st_jal: begin
                ctl    = {1'b1, 6'b0, 2'b00, 2'b01, 2'b10, 2'b00, 1'b0};
                nxt_st = st_aluwb;
            end
            st_jalr: begin
                ctl    = {1'b1, 6'b0, 2'b10, 2'b10, 2'b01, 2'b00, 1'b0};
                nxt_st = st_jalrwb;
            end
            st_jalrwb: begin
                ctl    = {6'b0, 1'b1, 2'b10, 2'b01, 2'b10, 2'b00, 1'b0};
                nxt_st = st_fetch;
            end
            st_beq: begin
                ctl    = {1'b0, 1'b1, 5'b0, 2'b00, 2'b10, 2'b00, 2'b01, 1'b0};
                nxt_st = st_fetch;
            end
            st_lui: begin
                ctl    = {7'b0, 2'b00, 2'b11, 2'b01, 2'b00, 1'b0};
                nxt_st = st_aluwb;
            end
            st_illegal: begin
                ctl    = {15'b0, 1'b1};
                nxt_st = (ILLEGAL_HALT != 0) ? st_illegal : st_fetch;
            end
            default: nxt_st = st_fetch;
        endcase
    end

    always_comb begin
        imm = 3'b000;
        case (op)
            op_sw:   imm = 3'b001;
            op_b:    imm = 3'b010;
            op_lui:  imm = 3'b011;
            op_jal:  imm = 3'b100;
            default: imm = 3'b000;
        endcase
    end

    // Outputs are forced low combinationally so reset silences strobes without waiting for a clock.
    assign {pc_write, branch, adr_src, mem_read, mem_write, ir_write, reg_write,
            result_src, alu_src_a, alu_src_b, alu_op, illegal} = rst ? ctl : 16'b0;
    assign imm_src = rst ? imm : 3'b000;
    assign state   = cur_st;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: default build plus a halting, handshake-free build.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rst_h = 1'b0;
    logic [6:0] op = 7'b0;
    logic [6:0] op_h = 7'b0;
    logic       mem_ready = 1'b0;

    logic       pc_write, branch, adr_src, mem_read, mem_write, ir_write, reg_write, illegal;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
    logic [2:0] imm_src;
    logic [3:0] state;

    logic       pc_write_h, branch_h, adr_src_h, mem_read_h, mem_write_h, ir_write_h, reg_write_h, illegal_h;
    logic [1:0] result_src_h, alu_src_a_h, alu_src_b_h, alu_op_h;
    logic [2:0] imm_src_h;
    logic [3:0] state_h;

    logic [15:0] ctl, ctl_h;
    assign ctl   = {pc_write, branch, adr_src, mem_read, mem_write, ir_write, reg_write,
                    result_src, alu_src_a, alu_src_b, alu_op, illegal};
    assign ctl_h = {pc_write_h, branch_h, adr_src_h, mem_read_h, mem_write_h, ir_write_h, reg_write_h,
                    result_src_h, alu_src_a_h, alu_src_b_h, alu_op_h, illegal_h};

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mc_controller dut (
        .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
        .pc_write(pc_write), .branch(branch), .adr_src(adr_src), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
        .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .imm_src(imm_src), .illegal(illegal), .state(state)
    );

    mc_controller #(.MEM_HANDSHAKE(0), .ILLEGAL_HALT(1)) dut_h (
        .clk(clk), .rst(rst_h), .op(op_h), .mem_ready(mem_ready),
        .pc_write(pc_write_h), .branch(branch_h), .adr_src(adr_src_h), .mem_read(mem_read_h),
        .mem_write(mem_write_h), .ir_write(ir_write_h), .reg_write(reg_write_h),
        .result_src(result_src_h), .alu_src_a(alu_src_a_h), .alu_src_b(alu_src_b_h),
        .alu_op(alu_op_h), .imm_src(imm_src_h), .illegal(illegal_h), .state(state_h)
    );

    // Field order matches the ctl vectors above.
    function automatic logic [15:0] mk(input logic pcw, br, adr, mr, mw, irw, rw,
                                       input logic [1:0] rs, a, b, aop, input logic ill);
        return {pcw, br, adr, mr, mw, irw, rw, rs, a, b, aop, ill};
    endfunction

    logic [15:0] e_zero, e_fetch, e_fetch_wait, e_decode, e_memadr, e_memread, e_memwb, e_memwrite;
    logic [15:0] e_execr, e_execi, e_aluwb, e_jal, e_jalr, e_jalrwb, e_beq, e_lui, e_illegal;

    task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_st(input string tag, input logic [3:0] st, input logic [15:0] c, input logic [2:0] im);
        #1;
        cmp({tag, ".state"}, {12'b0, state}, {12'b0, st});
        cmp({tag, ".ctl"}, ctl, c);
        cmp({tag, ".imm"}, {13'b0, imm_src}, {13'b0, im});
    endtask

    task automatic expect_h(input string tag, input logic [3:0] st, input logic [15:0] c);
        #1;
        cmp({tag, ".state"}, {12'b0, state_h}, {12'b0, st});
        cmp({tag, ".ctl"}, ctl_h, c);
    endtask

    initial begin
        e_zero       = 16'b0;
        e_fetch      = mk(1,0,0,1,0,1,0, 2'b10, 2'b00, 2'b10, 2'b00, 0);
        e_fetch_wait = mk(0,0,0,1,0,0,0, 2'b10, 2'b00, 2'b10, 2'b00, 0);
        e_decode     = mk(0,0,0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b00, 0);
        e_memadr     = mk(0,0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b00, 0);
        e_memread    = mk(0,0,1,1,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
        e_memwb      = mk(0,0,0,0,0,0,1, 2'b01, 2'b00, 2'b00, 2'b00, 0);
        e_memwrite   = mk(0,0,1,0,1,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
        e_execr      = mk(0,0,0,0,0,0,0, 2'b00, 2'b10, 2'b00, 2'b10, 0);
        e_execi      = mk(0,0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b10, 0);
        e_aluwb      = mk(0,0,0,0,0,0,1, 2'b00, 2'b00, 2'b00, 2'b00, 0);
        e_jal        = mk(1,0,0,0,0,0,0, 2'b00, 2'b01, 2'b10, 2'b00, 0);
        e_jalr       = mk(1,0,0,0,0,0,0, 2'b10, 2'b10, 2'b01, 2'b00, 0);
        e_jalrwb     = mk(0,0,0,0,0,0,1, 2'b10, 2'b01, 2'b10, 2'b00, 0);
        e_beq        = mk(0,1,0,0,0,0,0, 2'b00, 2'b10, 2'b00, 2'b01, 0);
        e_lui        = mk(0,0,0,0,0,0,0, 2'b00, 2'b11, 2'b01, 2'b00, 0);
        e_illegal    = mk(0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 1);

        // Reset held across clock edges: everything quiet, even with a SW opcode present.
        op = 7'b0100011; mem_ready = 1'b1;
        expect_st("reset", 4'd0, e_zero, 3'b000);
        step(); step();
        expect_st("reset_clk", 4'd0, e_zero, 3'b000);

        // LW with mem_ready high, plus one FETCH wait cycle
        rst = 1'b1; op = 7'b0000011; mem_ready = 1'b0;
        expect_st("fetch_wait", 4'd0, e_fetch_wait, 3'b000);
        step();
        expect_st("fetch_hold", 4'd0, e_fetch_wait, 3'b000);
        mem_ready = 1'b1;
        expect_st("lw.fetch", 4'd0, e_fetch, 3'b000);
        step(); expect_st("lw.decode", 4'd1, e_decode, 3'b000);
        step(); expect_st("lw.memadr", 4'd2, e_memadr, 3'b000);
        step(); expect_st("lw.memread", 4'd3, e_memread, 3'b000);
        step(); expect_st("lw.memwb", 4'd4, e_memwb, 3'b000);
        step(); expect_st("lw.done", 4'd0, e_fetch, 3'b000);

        // SW with three wait cycles in MEMWRITE
        op = 7'b0100011;
        step(); expect_st("sw.decode", 4'd1, e_decode, 3'b001);
        step(); expect_st("sw.memadr", 4'd2, e_memadr, 3'b001);
        step(); mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            expect_st("sw.wait", 4'd5, e_memwrite, 3'b001);
            step();
        end
        mem_ready = 1'b1;
        expect_st("sw.last", 4'd5, e_memwrite, 3'b001);
        step(); expect_st("sw.done", 4'd0, e_fetch, 3'b001);

        // BEQ
        op = 7'b1100011;
        expect_st("b.fetch", 4'd0, e_fetch, 3'b010);
        step(); expect_st("b.decode", 4'd1, e_decode, 3'b010);
        step(); expect_st("b.beq", 4'd10, e_beq, 3'b010);
        step(); expect_st("b.done", 4'd0, e_fetch, 3'b010);

        // JALR
        op = 7'b1100111;
        step(); expect_st("jalr.decode", 4'd1, e_decode, 3'b000);
        step(); expect_st("jalr.jalr", 4'd12, e_jalr, 3'b000);
        step(); expect_st("jalr.wb", 4'd13, e_jalrwb, 3'b000);
        step(); expect_st("jalr.done", 4'd0, e_fetch, 3'b000);

        // R-type; opcode changes in EXECR must not divert the sequence
        op = 7'b0110011;
        step(); expect_st("r.decode", 4'd1, e_decode, 3'b000);
        step(); op = 7'b1111111;
        expect_st("r.execr", 4'd6, e_execr, 3'b000);
        step(); op = 7'b0110011;
        expect_st("r.aluwb", 4'd8, e_aluwb, 3'b000);
        step(); expect_st("r.done", 4'd0, e_fetch, 3'b000);

        // I-type
        op = 7'b0010011;
        step(); expect_st("i.decode", 4'd1, e_decode, 3'b000);
        step(); expect_st("i.execi", 4'd7, e_execi, 3'b000);
        step(); expect_st("i.aluwb", 4'd8, e_aluwb, 3'b000);
        step(); expect_st("i.done", 4'd0, e_fetch, 3'b000);

        // LUI
        op = 7'b0110111;
        step(); expect_st("lui.decode", 4'd1, e_decode, 3'b011);
        step(); expect_st("lui.lui", 4'd11, e_lui, 3'b011);
        step(); expect_st("lui.aluwb", 4'd8, e_aluwb, 3'b011);
        step(); expect_st("lui.done", 4'd0, e_fetch, 3'b011);

        // JAL
        op = 7'b1101111;
        step(); expect_st("jal.decode", 4'd1, e_decode, 3'b100);
        step(); expect_st("jal.jal", 4'd9, e_jal, 3'b100);
        step(); expect_st("jal.aluwb", 4'd8, e_aluwb, 3'b100);
        step(); expect_st("jal.done", 4'd0, e_fetch, 3'b100);

        // Unsupported opcode, non-halting build recovers after one cycle
        op = 7'b1111111;
        step(); expect_st("ill.decode", 4'd1, e_decode, 3'b000);
        step(); expect_st("ill.illegal", 4'd15, e_illegal, 3'b000);
        step(); expect_st("ill.done", 4'd0, e_fetch, 3'b000);

        // Reset during a MEMREAD wait aborts immediately
        op = 7'b0000011;
        step(); step(); step(); mem_ready = 1'b0;
        expect_st("rst.memread", 4'd3, e_memread, 3'b000);
        #2 rst = 1'b0;
        expect_st("rst.async", 4'd0, e_zero, 3'b000);
        step();
        expect_st("rst.held", 4'd0, e_zero, 3'b000);
        rst = 1'b1; mem_ready = 1'b1;
        expect_st("rst.release", 4'd0, e_fetch, 3'b000);
        step(); expect_st("rst.decode", 4'd1, e_decode, 3'b000);

        // Handshake-free build: memory states last one cycle even with mem_ready low
        mem_ready = 1'b0; op_h = 7'b0100011;
        step(); rst_h = 1'b1;
        expect_h("h.fetch", 4'd0, e_fetch);
        step(); expect_h("h.decode", 4'd1, e_decode);
        step(); expect_h("h.memadr", 4'd2, e_memadr);
        step(); expect_h("h.memwrite", 4'd5, e_memwrite);
        step(); expect_h("h.done", 4'd0, e_fetch);

        // Halting build stays in ILLEGAL until reset
        op_h = 7'b1111111;
        step(); expect_h("h.ill_decode", 4'd1, e_decode);
        for (int i = 0; i < 10; i++) begin
            step(); expect_h("h.halt", 4'd15, e_illegal);
        end
        rst_h = 1'b0;
        expect_h("h.rst", 4'd0, e_zero);
        step(); rst_h = 1'b1; op_h = 7'b0000011;
        expect_h("h.restart", 4'd0, e_fetch);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL provide parameter MEM_HANDSHAKE, default 1: 1 = memory states wait for mem_ready; 0 = mem_ready ignored and treated as 1.
REQ-002 SHALL provide parameter ILLEGAL_HALT, default 0: 1 = ILLEGAL state holds until reset; 0 = ILLEGAL returns to FETCH after one cycle.
REQ-003 Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- op  in  7  opcode of the instruction register.
- mem_ready  in  1  memory access completes this cycle.
- pc_write  out  1  load PC unconditionally.
- branch  out  1  load PC if the datapath branch condition holds.
- adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  load the instruction register and OldPC.
- reg_write  out  1  register file write.
- result_src  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult.
- alu_src_a  out  2  00 = PC, 01 = OldPC, 10 = rs1, 11 = zero.
- alu_src_b  out  2  00 = rs2, 01 = imm, 10 = constant 4.
- alu_op  out  2  00 = add, 01 = sub (branch compare), 10 = funct decode.
- imm_src  out  3  000 = I, 001 = S, 010 = B, 011 = U, 100 = J.
- illegal  out  1  unsupported opcode detected.
- state  out  4  current FSM state, for debug.

Function
REQ-004 SHALL implement a Moore FSM with these states and 4-bit encodings: FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4, MEMWRITE = 5, EXECR = 6, EXECI = 7, ALUWB = 8, JAL = 9, BEQ = 10, LUI = 11, JALR = 12, JALRWB = 13, ILLEGAL = 15.
REQ-005 SHALL decode the following opcodes: R = 0110011, I = 0010011, LW = 0000011, SW = 0100011, B = 1100011, JAL = 1101111, JALR = 1100111, LUI = 0110111.
REQ-006 SHALL drive imm_src combinationally from op in every state: I/LW/JALR -> 000, SW -> 001, B -> 010, LUI -> 011, JAL -> 100, others -> 000.
REQ-007 SHALL drive every output not listed for the current state to 0.
REQ-008 FETCH SHALL drive adr_src = 0, mem_read = 1, alu_src_a = 00, alu_src_b = 10, alu_op = 00, result_src = 10. It SHALL assert ir_write and pc_write only in a cycle where mem_ready = 1, then go to DECODE; otherwise it stays in FETCH.
REQ-009 DECODE SHALL drive alu_src_a = 01, alu_src_b = 01, alu_op = 00. Next state: LW/SW -> MEMADR, R -> EXECR, I -> EXECI, B -> BEQ, JAL -> JAL, JALR -> JALR, LUI -> LUI, other -> ILLEGAL.
REQ-010 MEMADR SHALL drive alu_src_a = 10, alu_src_b = 01, alu_op = 00. Next state: LW -> MEMREAD, SW -> MEMWRITE.
REQ-011 MEMREAD SHALL drive adr_src = 1, mem_read = 1, result_src = 00, and go to MEMWB when mem_ready = 1; otherwise it holds.
REQ-012 MEMWB SHALL drive result_src = 01, reg_write = 1, then go to FETCH.
REQ-013 MEMWRITE SHALL drive adr_src = 1, mem_write = 1, result_src = 00, and go to FETCH when mem_ready = 1; otherwise it holds with mem_write still asserted.
REQ-014 EXECR SHALL drive alu_src_a = 10, alu_src_b = 00, alu_op = 10 -> ALUWB. EXECI SHALL drive alu_src_a = 10, alu_src_b = 01, alu_op = 10 -> ALUWB.
REQ-015 ALUWB SHALL drive result_src = 00, reg_write = 1 -> FETCH.
REQ-016 JAL SHALL drive alu_src_a = 01, alu_src_b = 10, alu_op = 00, result_src = 00, pc_write = 1 -> ALUWB.
REQ-017 JALR SHALL drive alu_src_a = 10, alu_src_b = 01, alu_op = 00, result_src = 10, pc_write = 1 -> JALRWB. JALRWB SHALL drive alu_src_a = 01, alu_src_b = 10, alu_op = 00, result_src = 10, reg_write = 1 -> FETCH.
REQ-018 BEQ SHALL drive alu_src_a = 10, alu_src_b = 00, alu_op = 01, result_src = 00, branch = 1 -> FETCH.
REQ-019 LUI SHALL drive alu_src_a = 11, alu_src_b = 01, alu_op = 00 -> ALUWB.
REQ-020 ILLEGAL SHALL drive illegal = 1. With ILLEGAL_HALT = 0 it goes to FETCH after one cycle; with ILLEGAL_HALT = 1 it stays in ILLEGAL until reset.
REQ-021 Latency in cycles, with mem_ready always 1: R/I/LUI/B = 3 or 4 as listed (R, I, LUI = 4; B = 3), LW = 5, SW = 4, JAL = 4, JALR = 4. Each wait cycle with mem_ready = 0 adds one cycle.
REQ-022 With MEM_HANDSHAKE = 0, FETCH, MEMREAD and MEMWRITE SHALL each last exactly one cycle.
REQ-023 op changes while not in DECODE or MEMADR SHALL NOT affect state transitions.

Reset
REQ-024 While rst = 0, state SHALL be FETCH and all outputs SHALL be 0, including mem_read and illegal, regardless of clk.
REQ-025 Releasing rst SHALL start FETCH behaviour at the first clk edge. Reset asserted mid-instruction, including during a memory wait, SHALL abort the instruction with no further writes.

Verification
REQ-026 Apply op = 0000011 with mem_ready = 1 -> states 0, 1, 2, 3, 4; reg_write = 1 only in state 4, with result_src = 01.
REQ-027 Apply op = 0100011 with mem_ready held 0 for 3 cycles in MEMWRITE -> mem_write = 1 for 4 cycles, then FETCH; reg_write never asserted.
REQ-028 Apply op = 1100011 -> states 0, 1, 10, 0; branch = 1 and alu_op = 01 only in state 10; imm_src = 010 throughout.
REQ-029 Apply op = 1100111 -> states 12, 13 follow DECODE; pc_write = 1 in state 12, reg_write = 1 in state 13.
REQ-030 Apply op = 1111111 with ILLEGAL_HALT = 1 -> state = 15 and illegal = 1 held for 10 or more cycles. A following rst pulse -> state = 0 and illegal = 0.
REQ-031 Assert rst low in MEMREAD with mem_ready = 0 -> all outputs 0 immediately; after release, the first cycle is FETCH with mem_read = 1.
